// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared types and default widths for the FIFO read-side blocks
package fifo_pkg;

  localparam int unsigned BITW_DEF = 8;
  localparam int unsigned LENW_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } rd_state_t;

endpackage

// File: rtl/stream_skid_buf.sv
// rtl/stream_skid_buf.sv - 2-entry FIFO-order skid buffer; the head entry drives the stream
module stream_skid_buf #(
  parameter int unsigned W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_valid_i,
  input  logic [W-1:0] wr_data_i,
  output logic         rd_valid_o,
  output logic [W-1:0] rd_data_o,
  input  logic         rd_ready_i,
  output logic [1:0]   occ_o
);

  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic [1:0]   occ_q, occ_d;
  logic         acc;

  always_comb begin
    acc    = (occ_q != 2'd0) && rd_ready_i;
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    case ({wr_valid_i, acc})
      2'b10: begin
        if (occ_q == 2'd0) head_d = wr_data_i;
        else               tail_d = wr_data_i;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        // Write and accept together: the head advances, the new word queues behind it.
        if (occ_q == 2'd1) begin
          head_d = wr_data_i;
        end else begin
          head_d = tail_q;
          tail_d = wr_data_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  assign rd_valid_o = (occ_q != 2'd0);
  assign rd_data_o  = head_q;
  assign occ_o      = occ_q;

endmodule

// File: rtl/fifo_burst_reader.sv
// rtl/fifo_burst_reader.sv - drains burst_len FIFO words onto a valid/ready stream, tagging the last beat
module fifo_burst_reader
  import fifo_pkg::*;
#(
  parameter int unsigned BITW = BITW_DEF,
  parameter int unsigned LENW = LENW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [LENW-1:0] burst_len,
  input  logic [BITW-1:0] fifo_data,
  input  logic            fifo_empty,
  output logic            fifo_pop,
  output logic [BITW-1:0] m_data,
  output logic            m_valid,
  input  logic            m_ready,
  output logic            m_last,
  output logic            busy,
  output logic            done
);

  rd_state_t       state_q, state_d;
  logic [LENW-1:0] rem_q, rem_d;
  logic            done_q, done_d;
  logic [1:0]      occ;
  logic [BITW:0]   head;
  logic            head_valid;

  // Pop depends only on registered state and fifo_empty, never on m_ready.
  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    done_d   = 1'b0;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && (burst_len != '0)) begin
          state_d = RUN;
          rem_d   = burst_len;
        end
      end
      RUN: begin
        fifo_pop = !fifo_empty && (rem_q != '0) && (occ < 2'd2);
        if (fifo_pop) begin
          rem_d = rem_q - LENW'(1);
          if (rem_q == LENW'(1)) state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (head_valid && m_ready && head[BITW]) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
    end
  end

  stream_skid_buf #(.W(BITW + 1)) u_buf (
    .clk        (clk),
    .rst        (rst),
    .wr_valid_i (fifo_pop),
    .wr_data_i  ({(rem_q == LENW'(1)), fifo_data}),
    .rd_valid_o (head_valid),
    .rd_data_o  (head),
    .rd_ready_i (m_ready),
    .occ_o      (occ)
  );

  assign m_valid = head_valid;
  assign m_data  = head[BITW-1:0];
  assign m_last  = head_valid && head[BITW];
  assign busy    = (state_q != IDLE);
  assign done    = done_q;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb/tb_fifo_burst_reader.sv - self-checking bench with a queue-based reference model
module tb_fifo_burst_reader;

  localparam int BITW = 8;
  localparam int LENW = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [LENW-1:0] burst_len = '0;
  logic [BITW-1:0] fifo_data = '0;
  logic            fifo_empty = 1'b1;
  logic            fifo_pop;
  logic [BITW-1:0] m_data;
  logic            m_valid;
  logic            m_ready = 1'b0;
  logic            m_last;
  logic            busy;
  logic            done;

  always #5 clk = ~clk;

  fifo_burst_reader #(.BITW(BITW), .LENW(LENW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .burst_len  (burst_len),
    .fifo_data  (fifo_data),
    .fifo_empty (fifo_empty),
    .fifo_pop   (fifo_pop),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_last     (m_last),
    .busy       (busy),
    .done       (done)
  );

  int n_cmp = 0;
  int n_fail = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  logic [BITW-1:0] fifo_q[$];
  logic            pop_pending = 1'b0;

  function automatic void refresh();
    fifo_empty = (fifo_q.size() == 0);
    fifo_data  = fifo_empty ? '0 : fifo_q[0];
  endfunction

  task automatic push(input logic [BITW-1:0] v);
    fifo_q.push_back(v);
    refresh();
  endtask

  always @(posedge clk) begin
    #1;
    if (pop_pending && fifo_q.size() > 0) void'(fifo_q.pop_front());
    refresh();
  end

  // Reference model: burst is either active or not; words still to pop; queue of buffered beats.
  bit            chk_en = 1'b0;
  bit            mdl_active = 1'b0;
  bit            mdl_done = 1'b0;
  int            mdl_left = 0;
  logic [BITW:0] mdl_buf[$];
  int            beat_cnt = 0;
  int            last_cnt = 0;
  int            last_idx = 0;

  always @(negedge clk) begin
    bit exp_pop;
    bit exp_valid;
    bit was_active;
    exp_pop   = mdl_active && (mdl_left > 0) && (fifo_q.size() > 0) && (mdl_buf.size() < 2);
    exp_valid = (mdl_buf.size() > 0);
    if (chk_en) begin
      check("fifo_pop", fifo_pop, exp_pop);
      check("m_valid", m_valid, exp_valid);
      check("busy", busy, mdl_active);
      check("done", done, mdl_done);
      if (exp_valid) begin
        check("m_data", m_data, mdl_buf[0][BITW-1:0]);
        check("m_last", m_last, mdl_buf[0][BITW]);
      end else begin
        check("m_last_idle", m_last, 0);
      end
    end
    pop_pending = (fifo_pop === 1'b1);
    if (rst) begin
      mdl_active = 1'b0;
      mdl_done   = 1'b0;
      mdl_left   = 0;
      mdl_buf.delete();
    end else begin
      was_active = mdl_active;
      mdl_done   = 1'b0;
      if (exp_valid && m_ready) begin
        beat_cnt = beat_cnt + 1;
        if (mdl_buf[0][BITW]) begin
          last_cnt   = last_cnt + 1;
          last_idx   = beat_cnt;
          mdl_active = 1'b0;
          mdl_done   = 1'b1;
        end
        void'(mdl_buf.pop_front());
      end
      if (exp_pop) begin
        mdl_buf.push_back({(mdl_left == 1), fifo_q[0]});
        mdl_left = mdl_left - 1;
      end
      if (!was_active && start && burst_len != 0) begin
        mdl_active = 1'b1;
        mdl_left   = int'(burst_len);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_start(input int len);
    burst_len = LENW'(len);
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic clear_counts();
    beat_cnt = 0;
    last_cnt = 0;
    last_idx = 0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    while ((busy !== 1'b0 || done !== 1'b0) && n < budget) begin
      tick();
      n = n + 1;
    end
    check({name, "_timeout"}, (n < budget), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    int pushed;
    tick();
    chk_en = 1'b1;
    tick();
    @(negedge clk);
    check("rst_pop", fifo_pop, 0);
    check("rst_valid", m_valid, 0);
    check("rst_last", m_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_data", m_data, 0);
    tick();
    rst = 1'b0;
    tick();

    // Basic 4-word burst with literal per-cycle expectations.
    for (int i = 0; i < 4; i++) push(8'h10 + 8'(i));
    m_ready = 1'b1;
    clear_counts();
    do_start(4);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      check("t1_pop", fifo_pop, (c <= 4));
      check("t1_valid", m_valid, (c >= 2 && c <= 5));
      if (c >= 2 && c <= 5) check("t1_data", m_data, 32'h0e + c);
      check("t1_last", m_last, (c == 5));
      check("t1_done", done, (c == 6));
      tick();
    end

    // Backpressure: ready low cycles 2-5.
    for (int i = 0; i < 3; i++) push(8'h10 + 8'(i));
    m_ready = 1'b0;
    clear_counts();
    do_start(3);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 4) begin
        check("t2_pop_stall", fifo_pop, 0);
        check("t2_valid", m_valid, 1);
        check("t2_hold", m_data, 8'h10);
      end
      tick();
    end
    m_ready = 1'b1;
    wait_idle(50, "t2");
    check("t2_beats", beat_cnt, 3);
    check("t2_lasts", last_cnt, 1);

    // Underflow: second word arrives late.
    push(8'h21);
    clear_counts();
    do_start(2);
    repeat (4) tick();
    @(negedge clk);
    check("t3_busy", busy, 1);
    check("t3_valid", m_valid, 0);
    check("t3_last", m_last, 0);
    check("t3_beats_mid", beat_cnt, 1);
    tick();
    push(8'h22);
    wait_idle(50, "t3");
    check("t3_beats", beat_cnt, 2);
    check("t3_last_idx", last_idx, 2);

    // Zero-length start ignored; start during RUN ignored.
    push(8'h33);
    clear_counts();
    do_start(0);
    @(negedge clk);
    check("t4_busy0", busy, 0);
    check("t4_pop0", fifo_pop, 0);
    tick();
    for (int i = 0; i < 4; i++) push(8'h34 + 8'(i));
    do_start(3);
    do_start(7);
    wait_idle(50, "t4");
    check("t4_beats", beat_cnt, 3);
    check("t4_lasts", last_cnt, 1);
    check("t4_left", fifo_q.size(), 2);
    fifo_q.delete();
    refresh();

    // Reset in the middle of an 8-word burst, then a fresh 2-word burst.
    for (int i = 0; i < 8; i++) push(8'h40 + 8'(i));
    clear_counts();
    do_start(8);
    n = 0;
    while (beat_cnt < 3 && n < 20) begin
      tick();
      n = n + 1;
    end
    check("t5_reach3", (n < 20), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("t5_pop", fifo_pop, 0);
    check("t5_valid", m_valid, 0);
    check("t5_last", m_last, 0);
    check("t5_busy", busy, 0);
    check("t5_done", done, 0);
    check("t5_data", m_data, 0);
    tick();
    fifo_q.delete();
    refresh();
    push(8'h50);
    push(8'h51);
    clear_counts();
    do_start(2);
    wait_idle(50, "t5b");
    check("t5_beats", beat_cnt, 2);
    check("t5_last_idx", last_idx, 2);

    // Long burst with random ready and a slow, bursty supply.
    clear_counts();
    pushed = 0;
    for (int i = 0; i < 40; i++) begin
      push(8'($urandom));
      pushed = pushed + 1;
    end
    do_start(255);
    n = 0;
    while (!(busy === 1'b0 && done === 1'b0) && n < 5000) begin
      m_ready = ($urandom_range(0, 99) < 60);
      if (pushed < 255 && $urandom_range(0, 1) == 0) begin
        push(8'($urandom));
        pushed = pushed + 1;
      end
      tick();
      n = n + 1;
    end
    check("t6_timeout", (n < 5000), 1);
    check("t6_beats", beat_cnt, 255);
    check("t6_lasts", last_cnt, 1);
    check("t6_last_idx", last_idx, 255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_burst_reader.md
Name: fifo_burst_reader

Overview:
Read-side drain engine for the team's synchronous FIFO. It consumes the FIFO's asynchronous-read data and empty flag, and drives the pop strobe. It drains a software-requested number of words per burst onto a valid/ready stream, and tags the final beat with m_last. A 2-entry output buffer decouples the downstream ready from the FIFO pop path while sustaining one word per cycle.

Parameters:
BITW, 8, data width; must match the FIFO data width.
LENW, 8, width of the burst-length field; maximum burst is 2^LENW-1 words.

Ports:
clk  input  1  clock.
rst  input  1  reset: synchronous, active-high.
start  input  1  single-cycle burst request; sampled only in IDLE.
burst_len  input  LENW  words to drain; sampled with start.
fifo_data  input  BITW  FIFO head word, valid combinationally while fifo_empty=0.
fifo_empty  input  1  FIFO empty flag.
fifo_pop  output  1  pop strobe; FIFO advances its read pointer at the next edge.
m_data  output  BITW  stream data.
m_valid  output  1  stream valid.
m_ready  input  1  stream ready.
m_last  output  1  marks the final beat of the burst.
busy  output  1  high in RUN and FLUSH.
done  output  1  single-cycle pulse after the last beat is accepted.

Behaviour:
- Reset values: fifo_pop=0, m_valid=0, m_last=0, busy=0, done=0, m_data=0. Buffer occupancy=0, remaining=0, state=IDLE.
- rst asserted mid-burst drops all buffered words, with no done pulse. Words already popped from the FIFO are lost; this is accepted behaviour.
- FSM states: IDLE, RUN, FLUSH.
- IDLE:
  - start=1 and burst_len!=0: latch remaining=burst_len, go to RUN.
  - start with burst_len=0: ignored; stay IDLE, no done pulse.
- RUN:
  - fifo_pop = !fifo_empty && remaining!=0 && occ<2, where occ is the current buffer occupancy.
  - fifo_pop is combinational from registered state and fifo_empty only; no path from m_ready.
  - On pop, fifo_data is captured into the buffer at the same edge. last_tag = (remaining==1). remaining decrements.
  - When remaining reaches 0 at an edge, go to FLUSH.
- FLUSH: no pops. When the beat with last_tag is accepted (m_valid && m_ready && m_last), go to IDLE. done=1 for exactly the following cycle.
- Latency:
  - start accepted at edge 0 → RUN in cycle 1.
  - fifo_pop can be high in cycle 1.
  - m_valid is high in cycle 2 at the earliest.
- Throughput: with m_ready held high and the FIFO never empty, one beat per cycle; occupancy settles at 1.
- Buffer: 2-entry FIFO-order skid buffer.
  - Head drives m_data/m_last; m_valid = (occ!=0).
  - Simultaneous write and accept: occupancy is unchanged and order is preserved.
  - m_data and m_last are held stable while m_valid && !m_ready.
- FIFO underflow: fifo_empty=1 in RUN stalls popping without changing state. The burst resumes when data arrives; there is no timeout.
- start while busy=1 is ignored and is not queued.
- m_last is asserted on exactly one beat per burst, and that beat is the burst_len-th beat.
- Arithmetic: remaining is an LENW-bit down-counter with no wrap. Popping is gated at remaining=0.

Decomposition:
- Shared package fifo_pkg holds:
  - typedef enum logic [1:0] rd_state_t {IDLE, RUN, FLUSH};
  - the default BITW/LENW constants.
- Sub-module stream_skid_buf (parameters BITW+1 bits, depth 2) holds the data+last buffer and its valid/ready logic. The top level contains only the FSM, the counter and the pop logic.

Test Plan:
- FIFO pre-loaded with 0x10..0x13, burst_len=4, m_ready=1: fifo_pop high cycles 1-4; beats 0x10,0x11,0x12,0x13 in cycles 2-5; m_last only on 0x13; done high in cycle 6.
- Backpressure: burst_len=3, m_ready low for cycles 2-5:
  - occupancy reaches 2 and fifo_pop stops after two pops;
  - m_data holds 0x10 while stalled;
  - after ready returns, 3 beats arrive in order and done pulses once.
- Underflow: burst_len=2, one word in the FIFO, second word pushed 5 cycles later → one beat, then a stall with busy=1 and no m_last; the second beat then arrives with m_last=1.
- burst_len=0 start → state stays IDLE, busy=0, no pop, no done. A start pulse during RUN → ignored; the beat count equals the original burst_len.
- rst asserted in the middle of a burst_len=8 burst after 3 beats → next cycle all outputs are 0 and state is IDLE. A new start with burst_len=2 then drains correctly with m_last on beat 2.
- Random m_ready over a burst_len=255 burst → scoreboard confirms order and a single m_last on beat 255; no pop occurs while fifo_empty=1.
